// File: rtl/ibuf_seq_ctrl.sv
// ibuf_seq_ctrl: sequencer that turns a single-ported instruction buffer into a
// circular instruction queue (fetch pushes, issue pops). The buffer does exactly
// one registered write and one registered read of the old data at buf_index every
// cycle. This block decides whether a push or a pop owns that index.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   flush         synchronous queue clear; it has the highest priority
//   push_valid    fetch offers push_instr
//   push_instr    instruction from fetch
//   push_ready    the push is accepted this cycle if push_valid is also high
//   pop_req       issue requests the next instruction
//   pop_grant     a pop is performed this cycle
//   out_valid     the buffer read data holds the popped instruction this cycle
//   buf_index     buffer index
//   buf_instr_in  buffer write data (always push_instr)
//   full, empty   count == bs-1 / count == 0
//
// Optional build macro IBUF_SEQ_CTRL_OCC_EN adds two outputs:
//   occupancy     current entry count
//   err           sticky flag for push-while-full or pop-while-empty.
//                 It is cleared by flush or reset.
module ibuf_seq_ctrl #(
   parameter int unsigned Instr_word_size = 32,
   parameter int unsigned bs              = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push_valid,
   input  logic [Instr_word_size-1:0] push_instr,
   output logic                       push_ready,
   input  logic                       pop_req,
   output logic                       pop_grant,
   output logic                       out_valid,
   output logic [$clog2(bs)-1:0]      buf_index,
   output logic [Instr_word_size-1:0] buf_instr_in,
   output logic                       full,
   output logic                       empty
`ifdef IBUF_SEQ_CTRL_OCC_EN
   ,
   output logic [$clog2(bs)-1:0]      occupancy,
   output logic                       err
`endif
);

   localparam int unsigned IdxW = $clog2(bs);
   localparam logic [IdxW-1:0] One  = IdxW'(1);
   localparam logic [IdxW-1:0] Capy = IdxW'(bs - 1);

   logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
   logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
   logic [IdxW-1:0] count_q, count_d;
   logic            last_pop_q, last_pop_d;
   logic            out_valid_q;

   logic cand_push, cand_pop;
   logic pop_win, push_win, push_go;

   assign full         = (count_q == Capy);
   assign empty        = (count_q == '0);
   assign out_valid    = out_valid_q;
   assign buf_instr_in = push_instr;

   always_comb begin
      cand_push  = push_valid & ~full;
      cand_pop   = pop_req & ~empty;
      // On a conflict, pop wins unless the last grant was a pop.
      pop_win    = cand_pop & (~cand_push | ~last_pop_q);
      push_win   = cand_push & (~cand_pop | last_pop_q);
      pop_grant  = pop_win & ~flush;
      push_go    = push_win & ~flush;
      push_ready = ~full & ~flush & ~(cand_pop & ~last_pop_q);
      // When idle, wr_ptr is always a free slot, so the unconditional write is harmless.
      buf_index  = pop_grant ? rd_ptr_q : wr_ptr_q;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      last_pop_d = last_pop_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         last_pop_d = 1'b0;
      end else if (push_go) begin
         wr_ptr_d   = wr_ptr_q + One;
         count_d    = count_q + One;
         last_pop_d = 1'b0;
      end else if (pop_grant) begin
         rd_ptr_d   = rd_ptr_q + One;
         count_d    = count_q - One;
         last_pop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_pop_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         last_pop_q  <= last_pop_d;
         out_valid_q <= pop_grant;
      end
   end

`ifdef IBUF_SEQ_CTRL_OCC_EN
   logic err_q, err_d;

   assign occupancy = count_q;
   assign err       = err_q;

   always_comb begin
      err_d = err_q | (push_valid & full) | (pop_req & empty);
      if (flush) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   // Occupancy and error reporting are not built.
`endif

endmodule

// File: tb/tb_ibuf_seq_ctrl.sv
module tb_ibuf_seq_ctrl;

   localparam int unsigned BS = 4;
   localparam int unsigned W  = 32;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          push_valid;
   logic [W-1:0]  push_instr;
   logic          push_ready;
   logic          pop_req;
   logic          pop_grant;
   logic          out_valid;
   logic [1:0]    buf_index;
   logic [W-1:0]  buf_instr_in;
   logic          full;
   logic          empty;
`ifdef IBUF_SEQ_CTRL_OCC_EN
   logic [1:0]    occupancy;
   logic          err;
`endif

   ibuf_seq_ctrl #(
      .Instr_word_size(W),
      .bs             (BS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .push_valid  (push_valid),
      .push_instr  (push_instr),
      .push_ready  (push_ready),
      .pop_req     (pop_req),
      .pop_grant   (pop_grant),
      .out_valid   (out_valid),
      .buf_index   (buf_index),
      .buf_instr_in(buf_instr_in),
      .full        (full),
      .empty       (empty)
`ifdef IBUF_SEQ_CTRL_OCC_EN
      ,
      .occupancy   (occupancy),
      .err         (err)
`endif
   );

   // Single-ported buffer: registered read of old data, then unconditional write.
   logic [W-1:0] mem [BS];
   logic [W-1:0] instr_out;
   always @(posedge clk) begin
      instr_out      <= mem[buf_index];
      mem[buf_index] <= buf_instr_in;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [1:0]   m_wr, m_rd;
   int           m_cnt;
   logic         m_last, m_ov, m_err;
   logic [W-1:0] exp_q[$];

   task automatic model_reset();
      m_wr = '0; m_rd = '0; m_cnt = 0; m_last = 1'b0; m_ov = 1'b0; m_err = 1'b0;
      exp_q.delete();
   endtask

   // Drive one cycle (starting just after a rising edge), check, then advance the model.
   task automatic step(input logic pv, input logic [W-1:0] pi, input logic pr, input logic fl);
      logic m_full, m_empty, c_push, c_pop, g_push, g_pop, e_ready;
      push_valid = pv; push_instr = pi; pop_req = pr; flush = fl;
      #3;
      m_full  = (m_cnt == BS - 1);
      m_empty = (m_cnt == 0);
      c_push  = pv & ~m_full;
      c_pop   = pr & ~m_empty;
      g_pop   = c_pop & (~c_push | ~m_last) & ~fl;
      g_push  = c_push & (~c_pop | m_last) & ~fl;
      e_ready = ~m_full & ~fl & ~(c_pop & ~m_last);
      check("push_ready", push_ready, e_ready);
      check("pop_grant", pop_grant, g_pop);
      check("buf_index", buf_index, g_pop ? m_rd : m_wr);
      check("buf_instr_in", buf_instr_in, pi);
      check("full", full, m_full);
      check("empty", empty, m_empty);
      check("out_valid", out_valid, m_ov);
`ifdef IBUF_SEQ_CTRL_OCC_EN
      check("occupancy", occupancy, m_cnt[1:0]);
      check("err", err, m_err);
`endif
      if (out_valid) begin
         if (exp_q.size() == 0) check("sb_underflow", 1, 0);
         else check("instr_out", instr_out, exp_q.pop_front());
      end
      @(posedge clk);
      if (fl) begin
         model_reset();
      end else begin
         m_err = m_err | (pv & m_full) | (pr & m_empty);
         if (g_push) begin
            exp_q.push_back(pi);
            m_wr++; m_cnt++; m_last = 1'b0;
         end
         if (g_pop) begin
            m_rd++; m_cnt--; m_last = 1'b1;
         end
         m_ov = g_pop;
      end
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; push_instr = '0; pop_req = 1'b0;
      model_reset();
      #3;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: fill to capacity, then a fourth push is held
      step(1, 32'hA, 0, 0);
      step(1, 32'hB, 0, 0);
      step(1, 32'hC, 0, 0);
      step(1, 32'hD, 0, 0);
      step(1, 32'hD, 0, 0);
      // 2: drain in order
      repeat (3) step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);

      // 3: one entry, then push and pop requested together
      step(1, 32'h300, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 32'h310 + i, 1, 0);
      repeat (3) step(0, '0, 1, 0);

      // 4: ten instructions streamed through with irregular pops, pointers wrap
      for (int i = 0; i < 10; i++) step(1, 32'h400 + i, ($urandom_range(0, 2) == 0), 0);
      repeat (6) step(0, '0, 1, 0);
      for (int i = 0; i < 10; i++) step(($urandom_range(0, 1) == 1), 32'h480 + i, 1'b1, 0);
      repeat (5) step(0, '0, 1, 0);

      // 5: flush with two entries and both requests, then push lands at index 0
      step(1, 32'h500, 0, 0);
      step(1, 32'h501, 0, 0);
      step(1, 32'h502, 1, 1);
      step(1, 32'h503, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);

      // 6: asynchronous reset mid-stream
      step(1, 32'h600, 0, 0);
      step(1, 32'h601, 0, 0);
      step(1, 32'h602, 0, 0);
      step(0, '0, 1, 0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_full", full, 1'b0);
      check("arst_empty", empty, 1'b1);
`ifdef IBUF_SEQ_CTRL_OCC_EN
      check("arst_occupancy", occupancy, 2'd0);
`endif
      model_reset();
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Pop while empty sets err, which holds until flush
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      step(1, 32'h700, 0, 0);
      step(0, '0, 0, 1);
      step(0, '0, 0, 0);
      step(1, 32'h701, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
